// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module   : pc_sequencer_if
// Purpose  : PC, instruction-memory and datapath handshake bundle for the
//            fetch/update sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
  parameter int AW = 12,
  parameter int IW = 16
) ();

  logic          start;
  logic [AW-1:0] pc_in;
  logic          loadPC;
  logic          incPC;
  logic [AW-1:0] pc_load_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] ir;
  logic          exec_start;
  logic          exec_done;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          halted;
  logic          fault;
  logic          busy;
  logic [15:0]   instr_count;

  modport master (
    input  start, pc_in, imem_ack, imem_data, exec_done, branch_taken, branch_target,
    output loadPC, incPC, pc_load_addr, imem_req, imem_addr, ir, exec_start,
           halted, fault, busy, instr_count
  );

  modport slave (
    output start, pc_in, imem_ack, imem_data, exec_done, branch_taken, branch_target,
    input  loadPC, incPC, pc_load_addr, imem_req, imem_addr, ir, exec_start,
           halted, fault, busy, instr_count
  );

endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch -> decode -> execute -> PC-update controller with HALT,
//            memory-timeout fault and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int         AW       = 12,
  parameter int         IW       = 16,
  parameter logic [3:0] HALT_OP  = 4'hF,
  parameter int         WAIT_MAX = 8
) (
  input  logic           clk,
  input  logic           rstn,
  pc_sequencer_if.master bus
);

  localparam int            CW          = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] C_WAIT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_UPDATE = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_wcnt;
  logic          r_imem_req;
  logic [AW-1:0] r_imem_addr;
  logic [IW-1:0] r_ir;
  logic          r_exec_start;
  logic          r_load;
  logic          r_inc;
  logic [AW-1:0] r_load_addr;
  logic          r_fault;
  logic [15:0]   r_instr_count;
  logic          r_no_retire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_ir          <= '0;
      r_exec_start  <= 1'b0;
      r_load        <= 1'b0;
      r_inc         <= 1'b0;
      r_load_addr   <= '0;
      r_fault       <= 1'b0;
      r_instr_count <= '0;
      r_no_retire   <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the transitions below raise them.
      r_exec_start <= 1'b0;
      r_load       <= 1'b0;
      r_inc        <= 1'b0;
      r_load_addr  <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_imem_addr <= bus.pc_in;
          r_imem_req  <= 1'b1;
          r_wcnt      <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            r_ir       <= bus.imem_data;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else if (r_wcnt == C_WAIT_LAST) begin
            r_fault    <= 1'b1;
            r_imem_req <= 1'b0;
            r_state    <= S_HALT;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (r_ir[IW-1 -: 4] == HALT_OP) begin
            r_state <= S_HALT;
          end else begin
            r_exec_start <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            r_load      <= bus.branch_taken;
            r_inc       <= ~bus.branch_taken;
            r_load_addr <= bus.branch_taken ? bus.branch_target : '0;
            r_no_retire <= 1'b0;
            r_state     <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!r_no_retire) r_instr_count <= r_instr_count + 16'd1;
          r_no_retire <= 1'b0;
          r_state     <= S_FETCH;
        end
        S_HALT: begin
          // Resume steps past the halting word without counting it.
          if (bus.start) begin
            r_inc       <= 1'b1;
            r_fault     <= 1'b0;
            r_no_retire <= 1'b1;
            r_state     <= S_UPDATE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.loadPC       = r_load;
  assign bus.incPC        = r_inc;
  assign bus.pc_load_addr = r_load_addr;
  assign bus.imem_req     = r_imem_req;
  assign bus.imem_addr    = r_imem_addr;
  assign bus.ir           = r_ir;
  assign bus.exec_start   = r_exec_start;
  assign bus.fault        = r_fault;
  assign bus.instr_count  = r_instr_count;
  assign bus.halted       = (r_state == S_HALT);
  assign bus.busy         = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer: directed table, corner
//            sequences and randomized instructions against a PC/count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pc_sequencer;

  localparam int         AW       = 12;
  localparam int         IW       = 16;
  localparam logic [3:0] HALT_OP  = 4'hF;
  localparam int         WAIT_MAX = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.AW(AW), .IW(IW)) bus ();

  pc_sequencer #(.AW(AW), .IW(IW), .HALT_OP(HALT_OP), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Environment program counter driven by the sequencer strobes.
  logic [AW-1:0] pc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn)           pc <= '0;
    else if (bus.loadPC) pc <= bus.pc_load_addr;
    else if (bus.incPC)  pc <= pc + 1'b1;
  end
  assign bus.pc_in = pc;

  typedef struct {
    logic [15:0] word;
    int          ack_dly;   // >= WAIT_MAX means memory never answers
    int          done_dly;
    logic        taken;
    logic [11:0] tgt;
    logic [11:0] exp_addr;
    logic [15:0] exp_cnt;
  } rec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [11:0] m_pc;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    int k = 0;
    while (bus.imem_req !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    ok = (bus.imem_req === 1'b1);
    if (!ok) chk("imem_req_wait", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic resume(input logic [15:0] exp_cnt);
    chk("halt_count_held", 32'(bus.instr_count), 32'(exp_cnt));
    step();
    chk("halt_no_strobe", 32'({bus.loadPC, bus.incPC}), 32'd0);
    chk("halt_still", 32'(bus.halted), 32'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("resume_incPC", 32'(bus.incPC), 32'd1);
    chk("resume_loadPC", 32'(bus.loadPC), 32'd0);
    chk("resume_fault_clr", 32'(bus.fault), 32'd0);
    chk("resume_halted", 32'(bus.halted), 32'd0);
    step();
    chk("resume_inc_once", 32'(bus.incPC), 32'd0);
    chk("resume_count", 32'(bus.instr_count), 32'(exp_cnt));
  endtask

  task automatic do_instr(input rec_t r);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    chk("imem_addr", 32'(bus.imem_addr), 32'(r.exp_addr));
    chk("busy_wait", 32'(bus.busy), 32'd1);
    if (r.ack_dly >= WAIT_MAX) begin
      repeat (WAIT_MAX - 1) begin
        bus.start = 1'($urandom);
        step();
      end
      bus.start = 1'b0;
      chk("pre_timeout_req", 32'(bus.imem_req), 32'd1);
      chk("pre_timeout_fault", 32'(bus.fault), 32'd0);
      step();
      chk("timeout_fault", 32'(bus.fault), 32'd1);
      chk("timeout_halted", 32'(bus.halted), 32'd1);
      chk("timeout_req", 32'(bus.imem_req), 32'd0);
      chk("timeout_busy", 32'(bus.busy), 32'd0);
      resume(r.exp_cnt);
      return;
    end
    repeat (r.ack_dly) begin
      bus.start = 1'($urandom);
      step();
    end
    bus.start     = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = r.word;
    step();
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'($urandom);
    chk("ir", 32'(bus.ir), 32'(r.word));
    chk("req_drop", 32'(bus.imem_req), 32'd0);
    chk("no_fault", 32'(bus.fault), 32'd0);
    step();
    if (r.word[15:12] == HALT_OP) begin
      chk("halt_halted", 32'(bus.halted), 32'd1);
      chk("halt_busy", 32'(bus.busy), 32'd0);
      chk("halt_exec_start", 32'(bus.exec_start), 32'd0);
      resume(r.exp_cnt);
      return;
    end
    chk("exec_start", 32'(bus.exec_start), 32'd1);
    repeat (r.done_dly) begin
      bus.start         = 1'($urandom);
      bus.branch_taken  = ~r.taken;
      bus.branch_target = 12'($urandom);
      step();
      chk("exec_start_once", 32'(bus.exec_start), 32'd0);
      chk("exec_no_strobe", 32'({bus.loadPC, bus.incPC}), 32'd0);
    end
    bus.start         = 1'b0;
    bus.exec_done     = 1'b1;
    bus.branch_taken  = r.taken;
    bus.branch_target = r.tgt;
    step();
    bus.exec_done     = 1'b0;
    bus.branch_taken  = 1'($urandom);
    bus.branch_target = 12'($urandom);
    chk("upd_loadPC", 32'(bus.loadPC), 32'(r.taken));
    chk("upd_incPC", 32'(bus.incPC), 32'(!r.taken));
    chk("upd_load_addr", 32'(bus.pc_load_addr), r.taken ? 32'(r.tgt) : 32'd0);
    step();
    chk("fetch_strobes_off", 32'({bus.loadPC, bus.incPC}), 32'd0);
    chk("instr_count", 32'(bus.instr_count), 32'(r.exp_cnt));
  endtask

  // Reference model: pick a random instruction and advance PC/count by the rules.
  task automatic build_rec(output rec_t r);
    bit stops;
    r.word = 16'($urandom);
    if ($urandom_range(0, 7) == 0)     r.word[15:12] = HALT_OP;
    else if (r.word[15:12] == HALT_OP) r.word[15:12] = 4'hE;
    r.ack_dly  = ($urandom_range(0, 9) == 0) ? WAIT_MAX : int'($urandom_range(0, WAIT_MAX - 1));
    r.done_dly = int'($urandom_range(0, 4));
    r.taken    = 1'($urandom);
    r.tgt      = 12'($urandom);
    r.exp_addr = m_pc;
    stops = (r.ack_dly >= WAIT_MAX) || (r.word[15:12] == HALT_OP);
    if (stops) begin
      r.exp_cnt = m_cnt;
      m_pc      = m_pc + 12'd1;
    end else begin
      m_cnt     = m_cnt + 16'd1;
      r.exp_cnt = m_cnt;
      m_pc      = r.taken ? r.tgt : m_pc + 12'd1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},     32'(bus.imem_req), 32'd0);
    chk({tag, "_addr"},    32'(bus.imem_addr), 32'd0);
    chk({tag, "_ir"},      32'(bus.ir), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_halted"},  32'(bus.halted), 32'd0);
    chk({tag, "_fault"},   32'(bus.fault), 32'd0);
    chk({tag, "_count"},   32'(bus.instr_count), 32'd0);
    chk({tag, "_strobes"}, 32'({bus.loadPC, bus.incPC, bus.exec_start}), 32'd0);
    chk({tag, "_ldaddr"},  32'(bus.pc_load_addr), 32'd0);
  endtask

  task automatic idle_quiet(input string tag);
    repeat (3) begin
      step();
      chk({tag, "_idle"}, 32'({bus.busy, bus.imem_req, bus.loadPC, bus.incPC}), 32'd0);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  rec_t tbl [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    bit   ok;
    tbl[0] = '{16'h1234, 0,        0, 1'b0, 12'h000, 12'h000, 16'd1};
    tbl[1] = '{16'h2000, 0,        3, 1'b1, 12'h0A5, 12'h001, 16'd2};
    tbl[2] = '{16'h3333, 2,        1, 1'b0, 12'h000, 12'h0A5, 16'd3};
    tbl[3] = '{16'h4444, 7,        0, 1'b1, 12'hFFF, 12'h0A6, 16'd4};
    tbl[4] = '{16'h5555, 0,        0, 1'b0, 12'h000, 12'hFFF, 16'd5};
    tbl[5] = '{16'hF000, 1,        0, 1'b0, 12'h000, 12'h000, 16'd5};
    tbl[6] = '{16'h6666, WAIT_MAX, 0, 1'b0, 12'h000, 12'h001, 16'd5};
    tbl[7] = '{16'h7777, 0,        2, 1'b0, 12'h000, 12'h002, 16'd6};
    tbl[8] = '{16'h8123, 0,        0, 1'b1, 12'h000, 12'h003, 16'd7};
    tbl[9] = '{16'h9ABC, 0,        0, 1'b0, 12'h000, 12'h000, 16'd8};

    bus.start = 1'b0;  bus.imem_ack = 1'b0;  bus.imem_data = '0;
    bus.exec_done = 1'b0;  bus.branch_taken = 1'b0;  bus.branch_target = '0;

    repeat (2) step();
    chk_all_zero("reset");
    rstn = 1'b1;
    idle_quiet("post_reset");
    pulse_start();

    foreach (tbl[i]) do_instr(tbl[i]);

    // Counter wrap: preload 16'hFFFF while no retirement is in flight.
    force dut.r_instr_count = 16'hFFFF;
    step();
    release dut.r_instr_count;
    chk("preload_count", 32'(bus.instr_count), 32'hFFFF);
    r = '{16'hA000, 0, 0, 1'b0, 12'h000, 12'h001, 16'h0000};
    do_instr(r);

    // Async reset in the middle of WAIT.
    wait_req(ok);
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_wait");
    @(negedge clk);
    rstn = 1'b1;
    idle_quiet("rst_wait");

    // Async reset in the first EXEC cycle.
    pulse_start();
    wait_req(ok);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h1111;
    step();
    bus.imem_ack  = 1'b0;
    step();
    chk("rst_exec_start_pre", 32'(bus.exec_start), 32'd1);
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_exec");
    @(negedge clk);
    rstn = 1'b1;
    idle_quiet("rst_exec");

    // Randomized instruction stream against the model.
    m_pc  = '0;
    m_cnt = '0;
    pulse_start();
    for (int n = 0; n < 150; n++) begin
      build_rec(r);
      do_instr(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
